// File: rtl/alu_atomic_scheduler.sv
// Round-robin command scheduler sharing one external ALU and an 8x32 register file.
// Commands run IDLE->READ->EXEC->WB one at a time, so CAS is atomic.
module alu_atomic_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*12-1:0] req_cmd,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [2:0]            alu_op_code,
  output logic [DATA_W-1:0]     data_a,
  output logic [DATA_W-1:0]     data_b,
  input  logic [DATA_W-1:0]     alu_y,
  input  logic                  alu_O,
  input  logic                  alu_C,
  input  logic                  alu_Z,
  input  logic                  alu_N,
  output logic                  rsp_valid,
  output logic [ID_W-1:0]       rsp_id,
  output logic [DATA_W-1:0]     rsp_data,
  output logic [3:0]            rsp_flags,
  output logic                  rsp_cas_ok,
  output logic                  busy
);

  localparam logic [2:0] OP_CAS = 3'b111;
  localparam logic [2:0] OP_SUB = 3'b001;

  typedef enum logic [1:0] {
    IDLE, READ, EXEC, WB
  } state_t;

  state_t state, state_nxt;

  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   id_q;
  logic [ID_W-1:0]   gnt_id;
  logic              gnt_any;
  int                gnt_scan;
  logic [11:0]       cmd_q;
  logic [DATA_W-1:0] y_q;
  logic              z_q;
  logic [DATA_W-1:0] rf [8];

  logic [2:0] op;
  logic [2:0] a1;
  logic [2:0] a2;
  logic [2:0] a3;
  logic       is_cas;

  assign op     = cmd_q[11:9];
  assign a1     = cmd_q[8:6];
  assign a2     = cmd_q[5:3];
  assign a3     = cmd_q[2:0];
  assign is_cas = (op == OP_CAS);

  // Scan from farthest to nearest so the first index after rr_ptr wins.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_id   = '0;
    gnt_scan = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      gnt_scan = (int'(rr_ptr) + k) % NUM_REQ;
      if (req_valid[ID_W'(gnt_scan)]) begin
        gnt_any = 1'b1;
        gnt_id  = ID_W'(gnt_scan);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (gnt_any) state_nxt = READ;
      READ:    state_nxt = EXEC;
      EXEC:    state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    busy      = (state != IDLE);
    if (state == IDLE && gnt_any) begin
      req_ready[gnt_id] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr      <= ID_W'(NUM_REQ - 1);
      id_q        <= '0;
      cmd_q       <= '0;
      alu_op_code <= '0;
      data_a      <= '0;
      data_b      <= '0;
      y_q         <= '0;
      z_q         <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_data    <= '0;
      rsp_flags   <= '0;
      rsp_cas_ok  <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (gnt_any) begin
            cmd_q  <= req_cmd[12*gnt_id +: 12];
            id_q   <= gnt_id;
            rr_ptr <= gnt_id;
          end
        end
        READ: begin
          data_a      <= rf[a1];
          data_b      <= is_cas ? rf[a3] : rf[a2];
          alu_op_code <= is_cas ? OP_SUB : op;
        end
        EXEC: begin
          y_q        <= alu_y;
          z_q        <= alu_Z;
          rsp_valid  <= 1'b1;
          rsp_id     <= id_q;
          rsp_flags  <= {alu_O, alu_C, alu_Z, alu_N};
          rsp_data   <= is_cas ? data_a : alu_y;
          rsp_cas_ok <= is_cas & alu_Z;
        end
        default: ;
      endcase
    end
  end

  // Single write per command; CAS compare result decides the target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        rf[i] <= '0;
      end
    end else if (state == WB) begin
      if (!is_cas) begin
        rf[a3] <= y_q;
      end else if (z_q) begin
        rf[a1] <= rf[a2];
      end else begin
        rf[a3] <= data_a;
      end
    end
  end

endmodule

// File: tb/tb_alu_atomic_scheduler.sv
// Bench for alu_atomic_scheduler: mock ALU, directed steps, then random rounds
// checked against a register-file and arbitration model.
module tb_alu_atomic_scheduler;

  localparam int NR = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NR-1:0] req_valid;
  logic [47:0]   req_cmd;
  logic [NR-1:0] req_ready;
  logic [2:0]    alu_op_code;
  logic [31:0]   data_a;
  logic [31:0]   data_b;
  logic [31:0]   alu_y;
  logic          alu_O, alu_C, alu_Z, alu_N;
  logic          rsp_valid;
  logic [1:0]    rsp_id;
  logic [31:0]   rsp_data;
  logic [3:0]    rsp_flags;
  logic          rsp_cas_ok;
  logic          busy;

  logic [31:0] ldi_val;
  logic [31:0] rf_m [8];
  int          last_grant;
  int          n_cmp = 0;
  int          n_mis = 0;

  localparam logic [11:0] HARM = {3'b010, 3'd7, 3'd7, 3'd7};

  alu_atomic_scheduler #(.NUM_REQ(NR), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_cmd(req_cmd), .req_ready(req_ready),
    .alu_op_code(alu_op_code), .data_a(data_a), .data_b(data_b),
    .alu_y(alu_y), .alu_O(alu_O), .alu_C(alu_C),
    .alu_Z(alu_Z), .alu_N(alu_N),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_flags(rsp_flags), .rsp_cas_ok(rsp_cas_ok), .busy(busy)
  );

  always #5 clk = ~clk;

  // Mock ALU: op 110 loads a bench-chosen immediate. Result is {O,C,Z,N,y}.
  function automatic logic [35:0] alu_f(
    input logic [2:0] op, input logic [31:0] a,
    input logic [31:0] b, input logic [31:0] imm);
    logic [32:0] w;
    logic [31:0] y;
    logic o, c;
    w = '0; y = '0; o = 1'b0; c = 1'b0;
    case (op)
      3'b000: begin
        w = {1'b0, a} + {1'b0, b}; y = w[31:0]; c = w[32];
        o = (a[31] == b[31]) && (y[31] != a[31]);
      end
      3'b001: begin
        w = {1'b0, a} - {1'b0, b}; y = w[31:0]; c = w[32];
        o = (a[31] != b[31]) && (y[31] != a[31]);
      end
      3'b010:  y = a & b;
      3'b011:  y = a | b;
      3'b100:  y = a ^ b;
      3'b101:  y = a << b[4:0];
      3'b110:  y = imm;
      default: y = a;
    endcase
    return {o, c, (y == 32'd0), y[31], y};
  endfunction

  assign {alu_O, alu_C, alu_Z, alu_N, alu_y} =
    alu_f(alu_op_code, data_a, data_b, ldi_val);

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [NR-1:0] mask);
    for (int k = 1; k <= NR; k++) begin
      if (mask[(last_grant + k) % NR]) return (last_grant + k) % NR;
    end
    return -1;
  endfunction

  function automatic logic [47:0] slot(input int rq, input logic [11:0] c);
    logic [47:0] v;
    v = {HARM, HARM, HARM, HARM};
    v[12*rq +: 12] = c;
    return v;
  endfunction

  function automatic logic [11:0] peek(input logic [2:0] r);
    return {3'b010, r, r, r};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) rf_m[i] = '0;
    last_grant = NR - 1;
  endtask

  // One granted command from the IDLE cycle through the return to IDLE.
  task automatic round(input logic [NR-1:0] mask, input logic [47:0] cmds,
                       input bit hold);
    int g;
    logic [11:0] c;
    logic [2:0]  op, a1, a2, a3, eop;
    logic [31:0] a, b, exp_data;
    logic [35:0] r;
    bit cas, ok;
    req_valid = mask;
    req_cmd   = cmds;
    #1;
    g = pick(mask);
    chk("grant", 32'(req_ready), 32'd1 << g);
    c  = cmds[12*g +: 12];
    op = c[11:9]; a1 = c[8:6]; a2 = c[5:3]; a3 = c[2:0];
    cas = (op == 3'b111);
    a   = rf_m[a1];
    b   = cas ? rf_m[a3] : rf_m[a2];
    eop = cas ? 3'b001 : op;
    r   = alu_f(eop, a, b, ldi_val);
    if (!cas) begin
      exp_data = r[31:0]; ok = 1'b0; rf_m[a3] = r[31:0];
    end else begin
      exp_data = a; ok = (a == b);
      if (ok) rf_m[a1] = rf_m[a2];
      else rf_m[a3] = a;
    end
    last_grant = g;
    @(posedge clk); #1;
    if (!hold) req_valid = '0;
    chk("read_busy", busy, 1);
    chk("read_ready", 32'(req_ready), 0);
    chk("read_rsp", rsp_valid, 0);
    @(posedge clk); #1;
    chk("exec_op", alu_op_code, eop);
    chk("exec_a", data_a, a);
    chk("exec_b", data_b, b);
    chk("exec_ready", 32'(req_ready), 0);
    @(posedge clk); #1;
    chk("wb_valid", rsp_valid, 1);
    chk("wb_id", rsp_id, g);
    chk("wb_data", rsp_data, exp_data);
    chk("wb_flags", rsp_flags, r[35:32]);
    chk("wb_cas_ok", rsp_cas_ok, ok);
    chk("wb_ready", 32'(req_ready), 0);
    chk("wb_busy", busy, 1);
    @(posedge clk); #1;
    chk("idle_valid", rsp_valid, 0);
    chk("idle_busy", busy, 0);
    chk("idle_hold", rsp_data, exp_data);
  endtask

  initial begin
    logic [NR-1:0] m;
    logic [47:0]   cv;
    logic [11:0]   c;
    rst_n = 1'b1; req_valid = '0; req_cmd = '0; ldi_val = '0;
    model_reset();
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_op", alu_op_code, 0);
    chk("rst_a", data_a, 0);
    chk("rst_b", data_b, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_flags", rsp_flags, 0);
    chk("rst_cas_ok", rsp_cas_ok, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD r1+r2 -> r3 on an all-zero file
    round(4'b0001, slot(0, {3'b000, 3'd1, 3'd2, 3'd3}), 1'b0);
    chk("add_zero_data", rsp_data, 0);

    // Preload r1=5, r2=5, r4=9 then a matching CAS
    ldi_val = 32'd5;
    round(4'b0001, slot(0, {3'b110, 3'd0, 3'd0, 3'd1}), 1'b0);
    round(4'b0001, slot(0, {3'b110, 3'd0, 3'd0, 3'd2}), 1'b0);
    ldi_val = 32'd9;
    round(4'b0001, slot(0, {3'b110, 3'd0, 3'd0, 3'd4}), 1'b0);
    round(4'b0001, slot(0, {3'b111, 3'd1, 3'd4, 3'd2}), 1'b0);
    chk("cas_hit_data", rsp_data, 5);
    chk("cas_hit_ok", rsp_cas_ok, 1);
    round(4'b0001, slot(0, peek(3'd1)), 1'b0);
    chk("cas_hit_r1", rsp_data, 9);

    // Mismatching CAS: r1=7 vs r2=5 updates r2
    ldi_val = 32'd7;
    round(4'b0001, slot(0, {3'b110, 3'd0, 3'd0, 3'd1}), 1'b0);
    round(4'b0001, slot(0, {3'b111, 3'd1, 3'd4, 3'd2}), 1'b0);
    chk("cas_miss_data", rsp_data, 7);
    chk("cas_miss_ok", rsp_cas_ok, 0);
    round(4'b0001, slot(0, peek(3'd2)), 1'b0);
    chk("cas_miss_r2", rsp_data, 7);
    round(4'b0001, slot(0, peek(3'd1)), 1'b0);
    chk("cas_miss_r1", rsp_data, 7);

    // CAS with addr1==addr3 always matches
    round(4'b0001, slot(0, {3'b111, 3'd2, 3'd4, 3'd2}), 1'b0);
    chk("cas_self_ok", rsp_cas_ok, 1);

    // All four held continuously: 0,1,2,3,0
    round(4'b1000, slot(3, HARM), 1'b0);
    for (int i = 0; i < 5; i++) begin
      round(4'b1111, {HARM, HARM, HARM, HARM}, 1'b1);
      chk("hold_order", rsp_id, i % NR);
    end
    req_valid = '0;

    // Only 1 and 3 valid after a grant to 3
    round(4'b1000, slot(3, HARM), 1'b0);
    round(4'b1010, {HARM, HARM, HARM, HARM}, 1'b0);
    chk("sparse_first", rsp_id, 1);
    round(4'b1010, {HARM, HARM, HARM, HARM}, 1'b0);
    chk("sparse_second", rsp_id, 3);

    // Reset during EXEC of a write to r5
    ldi_val   = 32'h0000ABCD;
    req_valid = 4'b0010;
    req_cmd   = slot(1, {3'b110, 3'd0, 3'd0, 3'd5});
    #1;
    chk("abort_grant", 32'(req_ready), 32'd1 << pick(4'b0010));
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    chk("abort_exec_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_rsp", rsp_valid, 0);
    chk("abort_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    chk("abort_after_rsp", rsp_valid, 0);
    chk("abort_after_busy", busy, 0);
    round(4'b1111, {HARM, HARM, HARM, peek(3'd5)}, 1'b0);
    chk("abort_winner", rsp_id, 0);
    chk("abort_r5", rsp_data, 0);

    // Random rounds
    for (int n = 0; n < 80; n++) begin
      m = 4'($urandom_range(0, 15));
      if (m == '0) begin
        req_valid = '0;
        #1;
        chk("rand_idle_ready", 32'(req_ready), 0);
        @(posedge clk); #1;
        chk("rand_idle_busy", busy, 0);
      end else begin
        for (int i = 0; i < NR; i++) begin
          c = 12'($urandom);
          if ($urandom_range(0, 2) == 0) c[11:9] = 3'b111;
          cv[12*i +: 12] = c;
        end
        ldi_val = $urandom;
        round(m, cv, 1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_mis);
    $finish;
  end

endmodule
